// File: rtl/niosballe_pio_pkg.sv
// Shared constants for the Nios "balle" PIO blocks: register map, edge kinds,
// bus request bundle and the per-bit edge selector.
package niosballe_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } pio_req_t;

  function automatic logic [31:0] edge_sel(input int etype, input logic [31:0] cur,
                                           input logic [31:0] prv);
    case (etype)
      EDGE_FALLING: edge_sel = ~cur & prv;
      EDGE_ANY:     edge_sel = cur ^ prv;
      default:      edge_sel = cur & ~prv;
    endcase
  endfunction

endpackage

// File: rtl/niosballe_pio_debounce.sv
// One-bit debouncer: dout follows the synchronized din only after din has
// disagreed with dout for CYCLES consecutive cycles. prime bypasses the filter.
module niosballe_pio_debounce #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic prime,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (prime) begin
      cnt  <= '0;
      dout <= din;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CW'(CYCLES)) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/niosballe_pio_in.sv
// Avalon-MM input PIO: 2-flop sync, conditioned value, sticky edge capture, level irq.
// Build option NIOSBALLE_PIO_IN_DEBOUNCE_EN replaces the plain conditioning flop with debouncers.
module niosballe_pio_in
  import niosballe_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] sync1, sync2, cond, prev, irqmask, edgecap, edge_det, clr;
  logic [1:0]       prime_cnt;
  logic             primed, priming;
  pio_req_t         req;
  logic             unused_wdata;

  assign req          = '{wr: chipselect && !write_n, addr: address, wdata: writedata};
  assign unused_wdata = ^req.wdata;
  assign primed       = (prime_cnt == 2'd3);
  assign priming      = !primed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      prime_cnt <= '0;
    end else begin
      sync1     <= in_port;
      sync2     <= sync1;
      prev      <= primed ? cond : sync2;
      prime_cnt <= primed ? prime_cnt : prime_cnt + 2'd1;
    end
  end

`ifdef NIOSBALLE_PIO_IN_DEBOUNCE_EN
  niosballe_pio_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db [WIDTH-1:0] (
    .clk    (clk),
    .reset_n(reset_n),
    .prime  (priming),
    .din    (sync2),
    .dout   (cond)
  );
`else
  // Priming and normal operation both load sync2; the distinction only matters with debounce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cond <= '0;
    else          cond <= sync2;
  end

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cfg
  end
`endif

  // Edges are masked until prev/cond hold real samples, so inputs high through reset never capture.
  assign edge_det = priming ? '0 : WIDTH'(edge_sel(EDGE_TYPE, 32'(cond), 32'(prev)));
  assign clr      = (req.wr && req.addr == PIO_ADDR_EDGECAP) ? req.wdata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      if (req.wr && req.addr == PIO_ADDR_IRQMASK) irqmask <= req.wdata[WIDTH-1:0];
      edgecap <= (edgecap & ~clr) | edge_det;
    end
  end

  assign irq = |(edgecap & irqmask);

  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:    readdata[WIDTH-1:0] = cond;
      PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
      default:          readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_niosballe_pio_in.sv
// Directed bench for niosballe_pio_in (WIDTH=4, rising edges); the debounce
// section runs only when NIOSBALLE_PIO_IN_DEBOUNCE_EN is defined.
module tb_niosballe_pio_in;
  localparam int W = 4;
  localparam int D = 8;
`ifdef NIOSBALLE_PIO_IN_DEBOUNCE_EN
  localparam int LAT = D + 3;
`else
  localparam int LAT = 3;
`endif

  logic          clk, reset_n, chipselect, write_n, irq;
  logic [1:0]    address;
  logic [31:0]   writedata, readdata, rdv;
  logic [W-1:0]  in_port;
  int            n_cmp = 0;
  int            n_err = 0;

  niosballe_pio_in #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // Drives the write for exactly one rising edge, returns at the following negedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0; in_port = 4'hF;
    cyc(3);
    rd(2'd0, rdv); chk("rst_data", rdv, 32'h0);
    rd(2'd3, rdv); chk("rst_edgecap", rdv, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    // inputs high through reset release must not capture
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      rd(2'd3, rdv); chk("prime_edgecap", rdv, 32'h0);
      chk("prime_irq", {31'b0, irq}, 32'h0);
    end
    rd(2'd0, rdv); chk("prime_data", rdv, 32'hF);

    in_port = 4'h0;
    cyc(LAT + 3);
    rd(2'd3, rdv); chk("fall_ignored", rdv, 32'h0);
    wr(2'd2, 32'h1);
    rd(2'd2, rdv); chk("irqmask_rb", rdv, 32'h1);

    // rising pulse on bit 0: capture exactly LAT+1 cycles after the change
    in_port[0] = 1'b1;
    cyc(LAT);
    rd(2'd0, rdv); chk("rise_data", rdv, 32'h1);
    rd(2'd3, rdv); chk("rise_early", rdv, 32'h0);
    chk("rise_early_irq", {31'b0, irq}, 32'h0);
    in_port[0] = 1'b0;
    cyc(1);
    rd(2'd3, rdv); chk("rise_cap", rdv, 32'h1);
    chk("rise_irq", {31'b0, irq}, 32'h1);
    cyc(LAT + 3);
    rd(2'd0, rdv); chk("pulse_fell", rdv, 32'h0);
    rd(2'd3, rdv); chk("fall_nocap", rdv, 32'h1);

    // clear, then clear again on the very cycle a new edge lands: set must win
    wr(2'd3, 32'h1);
    rd(2'd3, rdv); chk("clr0", rdv, 32'h0);
    chk("clr0_irq", {31'b0, irq}, 32'h0);
    in_port[0] = 1'b1;
    cyc(LAT);
    wr(2'd3, 32'h1);
    rd(2'd3, rdv); chk("set_wins", rdv, 32'h1);
    chk("set_wins_irq", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h0);
    rd(2'd3, rdv); chk("wr0_noop", rdv, 32'h1);
    wr(2'd3, 32'h1);
    rd(2'd3, rdv); chk("clr_last", rdv, 32'h0);
    chk("clr_last_irq", {31'b0, irq}, 32'h0);

    // masked captures, then unmask
    wr(2'd2, 32'h0);
    in_port = 4'b0111;
    cyc(LAT + 2);
    rd(2'd3, rdv); chk("masked_cap", rdv, 32'h6);
    chk("masked_irq", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h4);
    chk("unmask_irq", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'hFFFF_FFF4);
    rd(2'd2, rdv); chk("mask_upper_ign", rdv, 32'h4);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, rdv); chk("rsvd_rd", rdv, 32'h0);
    rd(2'd3, rdv); chk("rsvd_wr_noeff", rdv, 32'h6);

`ifdef NIOSBALLE_PIO_IN_DEBOUNCE_EN
    wr(2'd3, 32'hF);
    wr(2'd2, 32'h8);
    chk("db_irq_off", {31'b0, irq}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      in_port[3] = 1'b1; cyc(3);
      in_port[3] = 1'b0; cyc(3);
    end
    rd(2'd0, rdv); chk("db_bounce_data", rdv, 32'h7);
    rd(2'd3, rdv); chk("db_bounce_cap", rdv, 32'h0);
    in_port[3] = 1'b1;
    cyc(D + 2);
    rd(2'd0, rdv); chk("db_early", rdv, 32'h7);
    cyc(1);
    rd(2'd0, rdv); chk("db_rise", rdv, 32'hF);
    cyc(1);
    rd(2'd3, rdv); chk("db_cap", rdv, 32'h8);
    chk("db_irq", {31'b0, irq}, 32'h1);
    in_port[3] = 1'b0;
    cyc(5);
    rd(2'd0, rdv); chk("db_midcount", rdv, 32'hF);
`endif

    // asynchronous reset mid-operation with irq high
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1 chk("arst_irq", {31'b0, irq}, 32'h0);
    rd(2'd0, rdv); chk("arst_data", rdv, 32'h0);
    rd(2'd1, rdv); chk("arst_rsvd", rdv, 32'h0);
    rd(2'd2, rdv); chk("arst_mask", rdv, 32'h0);
    rd(2'd3, rdv); chk("arst_cap", rdv, 32'h0);
    cyc(2);
    reset_n = 1'b1;
    cyc(LAT + 3);
    rd(2'd0, rdv); chk("rerun_data", rdv, 32'h7);
    rd(2'd3, rdv); chk("rerun_cap", rdv, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/niosballe_pio_in.md
# niosballe_pio_in

Avalon-MM slave input PIO: the read-side counterpart of the system's output PIOs. It samples a `WIDTH`-bit external input bus, such as the paddle push-buttons or wall/brick sensors, through a two-flop synchronizer. It latches selected edges into a sticky edge-capture register and raises a level interrupt to the Nios II when any unmasked captured bit is set. It sits on the Nios system interconnect beside the output PIOs and uses the same slave signalling, with zero-wait-state combinational read data.

## Interface
Parameters:
- `WIDTH`, 4: number of input bits, 1..32.
- `EDGE_TYPE`, 0: edge captured. 0 = rising, 1 = falling, 2 = any.
- `DEBOUNCE_CYCLES`, 50000: stable cycles required before a debounced bit changes (1 ms at 50 MHz). Used only when debounce is compiled in. Minimum 1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  word register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data; bits above `WIDTH` are ignored.
- `in_port`  in  `WIDTH`  asynchronous external inputs.
- `readdata`  out  32  combinational read mux; upper bits are 0.
- `irq`  out  1  level interrupt.

## Operation
- Register map:
  - 0 DATA: read-only, current conditioned input.
  - 1: reserved; reads 0, writes ignored.
  - 2 IRQMASK: read/write.
  - 3 EDGECAPTURE: read; a write of 1 clears that bit, a write of 0 has no effect.
- A write occurs when `chipselect && !write_n`. Reads have no side effects.
- Conditioning path:
  - `in_port` goes through `sync1`, then `sync2`, producing the synchronized value.
  - The synchronized value feeds the conditioned register `cond`.
  - `prev` holds `cond` delayed by one cycle.
- Edge detect per bit:
  - rising = `cond & ~prev`
  - falling = `~cond & prev`
  - any = `cond ^ prev`
- A detected edge sets the EDGECAPTURE bit. On the same cycle for the same bit, **set wins over clear**.
- `irq = |(edgecapture & irqmask)`, built from registers only, with no combinational path from the bus.
- Priming:
  - A 2-bit counter counts 0..3 after reset, then saturates.
  - While it is below 3, `cond` and `prev` load directly from `sync2` and edge detection is inhibited.
  - An input held high through reset therefore never produces a spurious capture.
- Reset values: `sync1`, `sync2`, `cond`, `prev`, IRQMASK, EDGECAPTURE and the prime counter are all 0. `irq` = 0. `readdata` follows `address` combinationally.

## Timing
- `in_port` change to DATA visible, without debounce: 3 cycles (`sync1`, `sync2`, `cond`).
- Edge to EDGECAPTURE set: 4 cycles after the `in_port` change. `irq` asserts in the same cycle if the bit is unmasked.
- A write to IRQMASK or EDGECAPTURE takes effect on the next edge. `irq` follows one cycle after the write.
- A clear of the last set unmasked bit deasserts `irq` on the next cycle.
- Pulses shorter than one clock may be missed. No guarantee is made for them.
- Reset asserted mid-operation clears all state immediately (asynchronously). Priming restarts on release.

## Configuration
- Macro: `NIOSBALLE_PIO_IN_DEBOUNCE_EN`.
- Defined:
  - `cond` is a per-bit debounced value with a saturating counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - While `sync2 != cond` the counter increments. When it reaches `DEBOUNCE_CYCLES`, `cond` takes `sync2` and the counter resets.
  - Any cycle with `sync2 == cond` resets the counter.
  - Latency to DATA becomes `DEBOUNCE_CYCLES + 3` cycles.
  - Priming still loads `cond` directly.
- Undefined: `cond` = `sync2` registered, as described above. No counters are synthesized.

## Structure
- Package `niosballe_pio_pkg` holds:
  - register address constants `PIO_ADDR_DATA/RSVD/IRQMASK/EDGECAP`;
  - edge-type constants `EDGE_RISING/FALLING/ANY`.
- Sub-module `niosballe_pio_debounce`:
  - one bit: sync input, counter, stable output;
  - generated `WIDTH` times, only under the macro.

## Test plan
- Reset release with `in_port`=4'b1111 held -> EDGECAPTURE stays 0 and `irq` stays 0 for 20 cycles; DATA reads 0xF.
- `EDGE_TYPE`=0, IRQMASK=0x1, pulse `in_port[0]` 0→1 for 3 cycles -> EDGECAPTURE=0x1 and `irq`=1 exactly 4 cycles after the rise; the falling edge adds no capture.
- Write 0x1 to address 3 on the same cycle a new edge on bit 0 is detected -> bit 0 remains 1. A later clear with no edge -> EDGECAPTURE=0 and `irq`=0 next cycle.
- Capture edges on bits 1 and 2 with IRQMASK=0x0 -> EDGECAPTURE=0x6, `irq`=0. Write IRQMASK=0x4 -> `irq`=1 one cycle later.
- With the macro and `DEBOUNCE_CYCLES`=8, bounce bit 3 in 3-cycle pulses, then hold high for 10 cycles -> DATA bit 3 rises exactly 8 + 3 cycles after the final steady edge; one capture only.
- Assert `reset_n` mid-way through a debounce count with `irq`=1 -> all registers and `irq` go to 0 immediately; reads from address 1 return 0.
